alu_mc: RTL and testbench

- Parametrised, handshaked successor of the core's combinational ALU.
- Keeps the logic ops and add/set-less-than, and adds XOR, SUB, signed and unsigned compare, and shifts, all with one-cycle latency.
- Adds an iterative multiplier and an optional iterative unsigned divider.
- Sits in the EX stage; the pipeline stalls on a low `in_ready` or a low `out_valid`.

---
 rtl/alu_mc_pkg.sv | 37 +++
 rtl/alu_mc_iter.sv | 114 +++++++++++
 rtl/alu_mc.sv | 122 ++++++++++++
 tb/tb_alu_mc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and iterative-op decode for alu_mc.
// Build option: ALU_MC_DIV_EN enables the DIVU/REMU iterative divider.
package alu_mc_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd6;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd7;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd10;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd11;
    localparam logic [OP_W-1:0] OP_DIVU = 4'd12;
    localparam logic [OP_W-1:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops that take the multi-cycle path; divide ops only when the divider exists.
    function automatic logic is_iter(input logic [OP_W-1:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shift-add multiplier and restoring unsigned divider sharing one WIDTH-step counter.
// Build option: ALU_MC_DIV_EN includes the divider datapath.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [OP_W-1:0]  i_op_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_res_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_a;      // multiplicand (MUL) or dividend/quotient shifter (DIVU/REMU)
    logic [WIDTH-1:0] r_b;      // multiplier (MUL) or divisor (DIVU/REMU)
    logic [WIDTH-1:0] r_acc;

    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_rem_sh  = {r_rem, r_a[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_b};
        w_ge      = ~w_diff[WIDTH];
        w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo_nxt = {r_a[WIDTH-2:0], w_ge};
    end
`endif

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
        w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
        w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        if (r_op != OP_MUL) begin
            w_a_nxt = w_quo_nxt;
            w_b_nxt = r_b;
        end
`endif
    end

    // Final-step result is presented combinationally alongside the done pulse.
    always_comb begin
        case (r_op)
            OP_MUL:  o_res_c = w_acc_nxt;
`ifdef ALU_MC_DIV_EN
            OP_DIVU: o_res_c = w_quo_nxt;
            OP_REMU: o_res_c = w_rem_nxt;
`endif
            default: o_res_c = '0;
        endcase
    end

    assign o_done_c = r_busy & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= OP_AND;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
`ifdef ALU_MC_DIV_EN
            r_rem  <= '0;
`endif
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_op   <= i_op_sel;
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
`ifdef ALU_MC_DIV_EN
            r_rem  <= '0;
`endif
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_acc <= w_acc_nxt;
`ifdef ALU_MC_DIV_EN
            r_rem <= w_rem_nxt;
`endif
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked EX-stage ALU: one-cycle logic/arith/shift ops plus iterative MUL (and DIVU/REMU).
// Build option: ALU_MC_DIV_EN enables DIVU/REMU; otherwise opcodes 12/13 act as reserved.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_res;
    logic [WIDTH-1:0] w_alu_res;
    logic [SHW-1:0]   w_shamt;

    assign w_shamt = src_b[SHW-1:0];

    // One-cycle datapath; iterative and reserved opcodes fall through to zero.
    always_comb begin
        w_alu_res = '0;
        case (op)
            OP_AND:  w_alu_res = src_a & src_b;
            OP_OR:   w_alu_res = src_a | src_b;
            OP_NOR:  w_alu_res = ~(src_a | src_b);
            OP_ADD:  w_alu_res = src_a + src_b;
            OP_XOR:  w_alu_res = src_a ^ src_b;
            OP_SUB:  w_alu_res = src_a - src_b;
            OP_SLT:  w_alu_res = WIDTH'($signed(src_a) < $signed(src_b));
            OP_SLTU: w_alu_res = WIDTH'(src_a < src_b);
            OP_SLL:  w_alu_res = src_a << w_shamt;
            OP_SRL:  w_alu_res = src_a >> w_shamt;
            OP_SRA:  w_alu_res = WIDTH'($signed(src_a) >>> w_shamt);
            default: w_alu_res = '0;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_op_sel (op),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_done_c (w_iter_done),
        .o_res_c  (w_iter_res)
    );

    // Handshake FSM next-state and result capture.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter(op)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_result_nxt = w_alu_res;
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (w_iter_done) begin
                    w_result_nxt = w_iter_res;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_result    <= w_result_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_BUSY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver queues expected results, monitor checks on each output handshake.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q[$];
    string        nm_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: samples between the driver's negedge updates and the next posedge.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            check("result available for output", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [W-1:0] e;
                string        n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                check({n, " result"}, result, e);
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_lat, input int exp_busy,
                          input string name, input bit hold);
        int waits;
        int lat;
        int nbusy;
        int nrdy;
        waits = 0;
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check({name, " accepted"}, 64'(waits < 100), 64'd1);
        exp_q.push_back(exp);
        nm_q.push_back(name);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 4'($urandom_range(0, 15));
        lat = 1; nbusy = 0; nrdy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            if (in_ready) nrdy++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(nbusy), 64'(exp_busy));
        check({name, " in_ready while pending"}, 64'(nrdy), 64'd0);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                check({name, " held result"}, result, exp);
                check({name, " held out_valid"}, 64'(out_valid), 64'd1);
                check({name, " in_ready during hold"}, 64'(in_ready), 64'd0);
                @(negedge clk);
                in_valid = i[0]; op = OP_ADD; src_a = 32'd1; src_b = 32'd1;
                @(posedge clk); #1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            check({name, " in_ready at release"}, 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        check({name, " in_ready after take"}, 64'(in_ready), 64'd1);
        check({name, " out_valid after take"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; op = OP_ADD; src_a = 32'd1; src_b = 32'd2; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("no accept during reset", 64'(out_valid), 64'd0);

        run_op(OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, "ADD wrap", 1'b0);
        run_op(OP_SLT,  32'h8000_0000, 32'h1,         32'h1,         1, 0, "SLT", 1'b0);
        run_op(OP_SLTU, 32'h8000_0000, 32'h1,         32'h0,         1, 0, "SLTU", 1'b0);
        run_op(OP_SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1, 0, "SRA", 1'b0);
        run_op(OP_AND,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1, 0, "AND", 1'b0);
        run_op(OP_OR,   32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1, 0, "OR", 1'b0);
        run_op(OP_NOR,  32'h0000_F0F0, 32'h0000_0FF0, 32'hFFFF_000F, 1, 0, "NOR", 1'b0);
        run_op(OP_SLL,  32'h1,         32'h24,        32'h10,        1, 0, "SLL", 1'b0);
        run_op(OP_SRL,  32'h8000_0000, 32'h4,         32'h0800_0000, 1, 0, "SRL", 1'b0);
        run_op(4'd14,   32'h1234_5678, 32'h1,         32'h0,         1, 0, "reserved14", 1'b0);
        run_op(4'd15,   32'h1234_5678, 32'h1,         32'h0,         1, 0, "reserved15", 1'b0);

        run_op(OP_MUL,  32'h0001_0003, 32'h5,         32'h0005_000F, 33, 32, "MUL", 1'b0);
        run_op(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33, 32, "MUL all ones", 1'b0);

`ifdef ALU_MC_DIV_EN
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14,         33, 32, "DIVU", 1'b0);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2,          33, 32, "REMU", 1'b0);
        run_op(OP_DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF,  33, 32, "DIVU by zero", 1'b0);
        run_op(OP_REMU, 32'd5,   32'd0, 32'd5,          33, 32, "REMU by zero", 1'b0);
`else
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd0, 1, 0, "DIVU disabled", 1'b0);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd0, 1, 0, "REMU disabled", 1'b0);
`endif

        @(negedge clk);
        out_ready = 1'b0;
        run_op(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 0, "SUB hold", 1'b1);

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        op = OP_MUL; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("MUL busy before reset", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-op reset out_valid", 64'(out_valid), 64'd0);
        check("mid-op reset busy", 64'(busy), 64'd0);
        check("mid-op reset in_ready", 64'(in_ready), 64'd1);
        check("mid-op reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1, 0, "XOR after reset", 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
